tile_stream_feeder: RTL and testbench

Parametrised vector-stream source for the systolic array's row/column operand ports. It holds one operand tile in a local register file, issues one instruction word, then streams the tile as LANES-wide vectors under valid/ready for a programmable length and repeat count. Control is over the Avalon-style CSR slave. Two instances feed st_rows and st_cols of systolic_array_top.

---
 rtl/tile_stream_feeder.sv | 138 +++++++++++++
 tb/tb_tile_stream_feeder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/tile_stream_feeder.sv
// tile_stream_feeder: CSR-driven tile vector streamer with instruction issue; define SKEW_EN for systolic-skewed output
module tile_stream_feeder #(
    parameter int LANES   = 16,
    parameter int ELEM_W  = 8,
    parameter int DEPTH   = 16,
    parameter int AW      = $clog2(DEPTH),
    parameter int INSTR_W = 32
) (
    input  logic                      clock_sink,
    input  logic                      reset_sink_reset,
    input  logic [7:0]                csr_address,
    input  logic                      csr_write,
    input  logic [31:0]               csr_writedata,
    input  logic                      csr_read,
    output logic [31:0]               csr_readdata,
    input  logic                      ld_write,
    input  logic [AW-1:0]             ld_addr,
    input  logic [LANES*ELEM_W-1:0]   ld_data,
    output logic [INSTR_W-1:0]        st_instr_data,
    output logic                      st_instr_valid,
    input  logic                      st_instr_ready,
    output logic [LANES*ELEM_W-1:0]   st_data,
    output logic                      st_valid,
    input  logic                      st_ready,
    output logic                      st_last
);
    localparam int VW = LANES * ELEM_W;
    localparam int BW = $clog2(DEPTH + LANES);
    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, DONE} state_t;
    state_t state;
    logic [VW-1:0] mem [DEPTH];
    logic [AW:0] len_reg, run_len;
    logic [15:0] rep_reg, run_rep, p, beats;
    logic [INSTR_W-1:0] instr_reg;
    logic [BW-1:0] b, plen;
    logic done, aborted, cfg_err, ld_err;
    logic busy, start, abort, last_beat, last_pass;
    logic [VW-1:0] vec;
    logic [31:0] rdata;
    assign busy      = state != IDLE;
    assign start     = csr_write && csr_address == 8'h00 && csr_writedata[0];
    assign abort     = csr_write && csr_address == 8'h00 && csr_writedata[1];
    assign last_beat = b == plen - BW'(1);
    assign last_pass = p == run_rep - 16'd1;
    assign st_last   = st_valid && last_beat && last_pass;
    assign st_data   = st_valid ? vec : '0;
`ifdef SKEW_EN
    // Lane k lags by k beats; each pass is padded with LANES-1 trailing beats.
    assign plen = BW'(run_len) + BW'(LANES - 1);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [BW:0] t;
        assign t = {1'b0, b} - (BW+1)'(k);
        assign vec[k*ELEM_W +: ELEM_W] = (!t[BW] && t[BW-1:0] < BW'(run_len)) ?
                                         mem[t[AW-1:0]][k*ELEM_W +: ELEM_W] : '0;
    end
`else
    assign plen = BW'(run_len);
    assign vec  = mem[b[AW-1:0]];
`endif
    always_comb begin
        rdata = csr_address == 8'h01 ? {beats, 11'd0, ld_err, cfg_err, aborted, done, busy} :
                csr_address == 8'h02 ? 32'(len_reg) :
                csr_address == 8'h03 ? {16'd0, rep_reg} :
                csr_address == 8'h04 ? 32'(instr_reg) : '0;
    end
    always_ff @(posedge clock_sink or negedge reset_sink_reset) begin
        if (!reset_sink_reset) begin
            state          <= IDLE;
            csr_readdata   <= '0;
            st_instr_data  <= '0;
            st_instr_valid <= 1'b0;
            st_valid       <= 1'b0;
            len_reg        <= '0;
            run_len        <= '0;
            rep_reg        <= '0;
            run_rep        <= '0;
            instr_reg      <= '0;
            b              <= '0;
            p              <= '0;
            beats          <= '0;
            done           <= 1'b0;
            aborted        <= 1'b0;
            cfg_err        <= 1'b0;
            ld_err         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            csr_readdata <= csr_read ? rdata : '0;
            if (csr_write && csr_address == 8'h02) len_reg <= csr_writedata[AW:0];
            if (csr_write && csr_address == 8'h03) rep_reg <= csr_writedata[15:0];
            if (csr_write && csr_address == 8'h04) instr_reg <= INSTR_W'(csr_writedata);
            if (ld_write && busy) ld_err <= 1'b1;
            if (ld_write && !busy && {1'b0, ld_addr} < (AW+1)'(DEPTH)) mem[ld_addr] <= ld_data;
            if (abort && busy) begin
                state          <= IDLE;
                st_instr_valid <= 1'b0;
                st_valid       <= 1'b0;
                aborted        <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        if (len_reg == '0) cfg_err <= 1'b1;
                        else begin
                            state          <= ISSUE;
                            st_instr_valid <= 1'b1;
                            st_instr_data  <= instr_reg;
                            run_len        <= len_reg > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : len_reg;
                            run_rep        <= rep_reg == '0 ? 16'd1 : rep_reg;
                            b              <= '0;
                            p              <= '0;
                            beats          <= '0;
                            done           <= 1'b0;
                            aborted        <= 1'b0;
                            cfg_err        <= 1'b0;
                            ld_err         <= 1'b0;
                        end
                    end
                    ISSUE: if (st_instr_ready) begin
                        st_instr_valid <= 1'b0;
                        st_valid       <= 1'b1;
                        state          <= STREAM;
                    end
                    STREAM: if (st_ready) begin
                        if (beats != '1) beats <= beats + 16'd1;
                        if (last_beat && last_pass) begin
                            st_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else if (last_beat) begin
                            b <= '0;
                            p <= p + 16'd1;
                        end else b <= b + BW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tile_stream_feeder.sv
// tb_tile_stream_feeder: table-driven checks of tile_stream_feeder runs plus abort/error sequences
module tb_tile_stream_feeder;
`ifdef SKEW_EN
    localparam int L = 4;
`else
    localparam int L = 16;
`endif
    localparam int VW = L * 8;
    typedef struct {
        int          len;
        int          rep;
        bit          tog;
        logic [31:0] instr;
        int          beats;
        logic [31:0] status;
    } vec_t;
    vec_t tbl[$];
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] csr_address = '0;
    logic csr_write = 1'b0;
    logic [31:0] csr_writedata = '0;
    logic csr_read = 1'b0;
    logic [31:0] csr_readdata;
    logic ld_write = 1'b0;
    logic [3:0] ld_addr = '0;
    logic [VW-1:0] ld_data = '0;
    logic [31:0] st_instr_data;
    logic st_instr_valid;
    logic st_instr_ready = 1'b0;
    logic [VW-1:0] st_data;
    logic st_valid;
    logic st_ready = 1'b0;
    logic st_last;
    int n_chk = 0;
    int n_fail = 0;
    logic [31:0] rd;
    always #5 clk = ~clk;
    tile_stream_feeder #(.LANES(L)) dut (
        .clock_sink(clk), .reset_sink_reset(rst_n),
        .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_read(csr_read), .csr_readdata(csr_readdata),
        .ld_write(ld_write), .ld_addr(ld_addr), .ld_data(ld_data),
        .st_instr_data(st_instr_data), .st_instr_valid(st_instr_valid), .st_instr_ready(st_instr_ready),
        .st_data(st_data), .st_valid(st_valid), .st_ready(st_ready), .st_last(st_last)
    );
    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    function automatic logic [VW-1:0] rep_vec(input int v);
        return {L{8'(v)}};
    endfunction
    // Reference: entry i holds i+1 in every lane.
    function automatic logic [VW-1:0] exp_beat(input int j, input int len);
        logic [VW-1:0] v = '0;
`ifdef SKEW_EN
        int t = j % (len + L - 1);
        for (int k = 0; k < L; k++)
            if (t - k >= 0 && t - k < len) v[k*8 +: 8] = 8'(t - k + 1);
`else
        v = rep_vec(j % len + 1);
`endif
        return v;
    endfunction
    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        csr_write = 1'b1; csr_address = a; csr_writedata = d;
        @(negedge clk);
        csr_write = 1'b0;
    endtask
    task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
        csr_read = 1'b1; csr_address = a;
        @(negedge clk);
        csr_read = 1'b0;
        d = csr_readdata;
    endtask
    task automatic start_run(input vec_t r);
        csr_wr(8'h02, 32'(r.len));
        csr_wr(8'h03, 32'(r.rep));
        csr_wr(8'h04, r.instr);
        csr_wr(8'h00, 32'h1);
        chk("instr_valid", 128'(st_instr_valid), 128'(1));
        chk("instr_data", 128'(st_instr_data), 128'(r.instr));
        @(negedge clk);
        chk("instr_hold", 128'({st_instr_valid, st_valid}), 128'(2'b10));
        st_instr_ready = 1'b1;
        @(negedge clk);
        st_instr_ready = 1'b0;
        chk("stream_enter", 128'({st_instr_valid, st_valid}), 128'(2'b01));
    endtask
    task automatic stream_run(input vec_t r);
        int el = r.len > 16 ? 16 : r.len;
        int got = 0;
        bit stall = 0;
        logic [VW-1:0] prev = '0;
        for (int c = 0; c < 400 && got < r.beats; c++) begin
            st_ready = r.tog ? (c % 2 == 0) : 1'b1;
            if (stall) chk("stall_hold", 128'({st_valid, st_data}), 128'({1'b1, prev}));
            if (st_valid && st_ready) begin
                chk("beat_data", 128'(st_data), 128'(exp_beat(got, el)));
                chk("beat_last", 128'(st_last), 128'(got == r.beats - 1));
                got++;
                stall = 0;
            end else if (st_valid) begin
                stall = 1;
                prev = st_data;
            end
            @(negedge clk);
        end
        st_ready = 1'b0;
        chk("beat_count", 128'(got), 128'(r.beats));
        chk("valid_drop", 128'(st_valid), 128'(0));
        @(negedge clk);
        csr_rd(8'h01, rd);
        chk("status_done", 128'(rd), 128'(r.status));
    endtask
    initial begin
`ifdef SKEW_EN
        tbl.push_back('{4, 2, 1'b0, 32'h00010004, 14, 32'h000E0002});
        tbl.push_back('{2, 1, 1'b1, 32'h00020002, 5, 32'h00050002});
`else
        tbl.push_back('{16, 1, 1'b0, 32'h00010010, 16, 32'h00100002});
        tbl.push_back('{16, 1, 1'b1, 32'h00010010, 16, 32'h00100002});
        tbl.push_back('{4, 3, 1'b0, 32'hCAFE0004, 12, 32'h000C0002});
        tbl.push_back('{20, 0, 1'b1, 32'h12345678, 16, 32'h00100002});
        tbl.push_back('{1, 2, 1'b1, 32'hA5A5A5A5, 2, 32'h00020002});
`endif
        repeat (2) @(negedge clk);
        chk("rst_outputs", 128'({st_valid, st_instr_valid, st_last, st_data}), 128'(0));
        rst_n = 1'b1;
        @(negedge clk);
        csr_rd(8'h01, rd);
        chk("rst_status", 128'(rd), 128'(0));
        csr_wr(8'h03, 32'h0001_2345);
        csr_rd(8'h03, rd);
        chk("repeat_rdback", 128'(rd), 128'(32'h2345));
        csr_rd(8'h10, rd);
        chk("unmapped_rd", 128'(rd), 128'(0));
        csr_wr(8'h02, 32'h0);
        csr_wr(8'h00, 32'h1);
        chk("len0_idle", 128'(st_instr_valid), 128'(0));
        csr_rd(8'h01, rd);
        chk("len0_cfg_err", 128'(rd & 32'h9), 128'(32'h8));
        for (int i = 0; i < 16; i++) begin
            ld_write = 1'b1; ld_addr = 4'(i); ld_data = rep_vec(i + 1);
            @(negedge clk);
        end
        ld_write = 1'b0;
        for (int i = 0; i < tbl.size(); i++) begin
            start_run(tbl[i]);
            stream_run(tbl[i]);
        end
        start_run(tbl[0]);
        st_ready = 1'b1;
        repeat (5) @(negedge clk);
        st_ready = 1'b0;
        csr_wr(8'h00, 32'h2);
        chk("abort_valid", 128'({st_valid, st_instr_valid}), 128'(0));
        csr_rd(8'h01, rd);
        chk("abort_status", 128'(rd), 128'(32'h00050004));
        start_run(tbl[0]);
        stream_run(tbl[0]);
        start_run(tbl[0]);
        ld_write = 1'b1; ld_addr = 4'd3; ld_data = rep_vec(8'hEE);
        @(negedge clk);
        ld_write = 1'b0;
        csr_rd(8'h01, rd);
        chk("ld_err_set", 128'(rd & 32'h1F), 128'(32'h11));
        csr_wr(8'h00, 32'h3);
        csr_rd(8'h01, rd);
        chk("abort_wins", 128'(rd & 32'h7), 128'(32'h4));
        start_run(tbl[0]);
        stream_run(tbl[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
